// File: rtl/opc2_mem_arb.sv
// Two-port round-robin arbiter for the OPC2 byte memory, with a bounded burst lock.
// Port 0 is the CPU bus adapter and port 1 is the DMA/debug loader.
module opc2_mem_arb #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          rnw0,
  input  logic          rnw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rnw,
  output logic          mem_ce_b,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [4:0] LOCK_LIM = 5'(LOCK_MAX);

  owner_t     r_owner;
  logic       r_last;      // 0 = port 0 served last, 1 = port 1
  logic [3:0] r_hold_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_hold_ok;

  assign w_gnt0 = (r_owner == OWN_P0) && req0;
  assign w_gnt1 = (r_owner == OWN_P1) && req1;
  // Lock may extend ownership only while the next granted cycle stays below LOCK_MAX.
  assign w_hold_ok = (({1'b0, r_hold_cnt} + 5'd1) < LOCK_LIM);

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = mem_rdata;

  always_comb begin
    mem_ce_b  = 1'b1;
    mem_rnw   = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_ce_b  = 1'b0;
      mem_rnw   = rnw0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (w_gnt1) begin
      mem_ce_b  = 1'b0;
      mem_rnw   = rnw1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_owner    <= OWN_NONE;
      r_last     <= 1'b1;
      r_hold_cnt <= 4'd0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && rnw0;
      r_rvalid1 <= w_gnt1 && rnw1;
      case (r_owner)
        OWN_NONE: begin
          r_hold_cnt <= 4'd0;
          if (req0 && req1) r_owner <= r_last ? OWN_P0 : OWN_P1;
          else if (req0)    r_owner <= OWN_P0;
          else if (req1)    r_owner <= OWN_P1;
        end
        OWN_P0: begin
          if (req0) begin
            r_last <= 1'b0;
            if (!req1) begin
              r_hold_cnt <= 4'd0;
            end else if (lock0 && w_hold_ok) begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
              r_owner    <= OWN_P1;
              r_hold_cnt <= 4'd0;
            end
          end else begin
            r_owner    <= req1 ? OWN_P1 : OWN_NONE;
            r_hold_cnt <= 4'd0;
          end
        end
        OWN_P1: begin
          if (req1) begin
            r_last <= 1'b1;
            if (!req0) begin
              r_hold_cnt <= 4'd0;
            end else if (lock1 && w_hold_ok) begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
              r_owner    <= OWN_P0;
              r_hold_cnt <= 4'd0;
            end
          end else begin
            r_owner    <= req0 ? OWN_P0 : OWN_NONE;
            r_hold_cnt <= 4'd0;
          end
        end
        default: begin
          r_owner    <= OWN_NONE;
          r_hold_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opc2_mem_arb.sv
// Directed bench for opc2_mem_arb with a behavioural synchronous byte memory.
module tb_opc2_mem_arb;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          req0, req1, lock0, lock1, rnw0, rnw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rnw, mem_ce_b;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  opc2_mem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rnw0(rnw0), .rnw1(rnw1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rnw(mem_rnw), .mem_ce_b(mem_ce_b), .mem_rdata(mem_rdata)
  );

  // Memory model: write on a granted write, read data appears one clock after the address.
  always @(posedge clk) begin
    if (!mem_ce_b) begin
      if (!mem_rnw) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; rnw0 = 1; rnw1 = 1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_b = 0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_b = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      checks++;
      if ({gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata, rvalid0, rvalid1} !==
          {1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: gnt=%b%b ce_b=%b rnw=%b addr=%h wd=%h rv=%b%b want 00 1 1 000 00 00",
                 i, gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata, rvalid0, rvalid1);
      end
    end
    #1 reset_b = 1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      #2;
      checks++;
      if ({gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, rvalid0, rvalid1} !==
          {1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: gnt=%b%b ce_b=%b rnw=%b addr=%h rv=%b%b want 00 1 1 000 00",
                 i, gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, rvalid0, rvalid1);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1; rnw0 = 1; addr0 = 10'h155;
    #2;
    checks++;
    if (gnt0 !== 1'b0) begin errors++; $display("FAIL rd_c1_gnt0: got %b want 0", gnt0); end
    next_cyc(); #2;
    checks++;
    if ({gnt0, mem_ce_b, mem_rnw, mem_addr} !== {1'b1, 1'b0, 1'b1, 10'h155}) begin
      errors++;
      $display("FAIL rd_c2_grant: gnt0=%b ce_b=%b rnw=%b addr=%h want 1 0 1 155", gnt0, mem_ce_b, mem_rnw, mem_addr);
    end
    next_cyc();
    req0 = 0;
    #2;
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {1'b1, 1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd_c3_data: rv=%b%b rdata=%h want 10 a5", rvalid0, rvalid1, rdata);
    end
    next_cyc(); #2;
    checks++;
    if ({rvalid0, gnt0} !== 2'b00) begin
      errors++;
      $display("FAIL rd_c4_quiet: rvalid0=%b gnt0=%b want 0 0", rvalid0, gnt0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0 = 1; rnw0 = 0; addr0 = 10'h010; wdata0 = 8'h11;
    req1 = 1; rnw1 = 0; addr1 = 10'h020; wdata1 = 8'h22;
    #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL sim_c1: gnt=%b%b want 00", gnt0, gnt1); end
    next_cyc(); #2;
    checks++;
    if ({gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata} !== {2'b10, 1'b0, 1'b0, 10'h010, 8'h11}) begin
      errors++;
      $display("FAIL sim_c2_p0: gnt=%b%b ce_b=%b rnw=%b addr=%h wd=%h want 10 0 0 010 11",
               gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata);
    end
    next_cyc();
    req0 = 0;
    #2;
    checks++;
    if ({gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata} !== {2'b01, 1'b0, 1'b0, 10'h020, 8'h22}) begin
      errors++;
      $display("FAIL sim_c3_p1: gnt=%b%b ce_b=%b rnw=%b addr=%h wd=%h want 01 0 0 020 22",
               gnt0, gnt1, mem_ce_b, mem_rnw, mem_addr, mem_wdata);
    end
    next_cyc();
    req1 = 0;
    #2;
    checks++;
    if ({mem[10'h010], mem[10'h020]} !== {8'h11, 8'h22}) begin
      errors++;
      $display("FAIL sim_mem: [010]=%h [020]=%h want 11 22", mem[10'h010], mem[10'h020]);
    end
    clear_inputs();
  endtask

  task automatic test_lock_bound();
    logic [9:0] exp0;
    exp0 = 10'b0111101111;
    do_reset();
    req0 = 1; lock0 = 1; rnw0 = 1; addr0 = 10'h155;
    req1 = 1; rnw1 = 1; addr1 = 10'h020;
    #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL lock_c1: gnt=%b%b want 00", gnt0, gnt1); end
    for (int i = 0; i < 10; i++) begin
      next_cyc(); #2;
      checks++;
      if ({gnt0, gnt1} !== {exp0[i], ~exp0[i]}) begin
        errors++;
        $display("FAIL lock_seq cyc%0d: gnt=%b%b want %b%b", i + 2, gnt0, gnt1, exp0[i], ~exp0[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req1 = 1; rnw1 = 1; addr1 = 10'h020;
    next_cyc(); #2;
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL mid_grant: gnt1=%b want 1", gnt1); end
    next_cyc(); #2;
    checks++;
    if ({rvalid1, rdata, gnt1} !== {1'b1, 8'h22, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: rvalid1=%b rdata=%h gnt1=%b want 1 22 1", rvalid1, rdata, gnt1);
    end
    reset_b = 0;
    #1;
    checks++;
    if ({gnt1, rvalid1, mem_ce_b} !== 3'b001) begin
      errors++;
      $display("FAIL mid_async: gnt1=%b rvalid1=%b ce_b=%b want 0 0 1", gnt1, rvalid1, mem_ce_b);
    end
    req0 = 1; rnw0 = 1; addr0 = 10'h155;
    next_cyc();
    reset_b = 1;
    #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL mid_rel: gnt=%b%b want 00", gnt0, gnt1); end
    next_cyc(); #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL mid_tie: gnt=%b%b want 10", gnt0, gnt1); end
    clear_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    req1 = 1; rnw1 = 1; addr1 = 10'h030; lock1 = 1;
    next_cyc();
    req0 = 1; rnw0 = 1; addr0 = 10'h155;
    #2;
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL wd_grant1: gnt=%b%b want 01", gnt0, gnt1); end
    next_cyc();
    req1 = 0; rnw1 = 0; wdata1 = 8'h77;
    #2;
    checks++;
    if ({gnt0, gnt1, mem_ce_b, mem_rnw, rvalid1, rdata} !== {2'b00, 1'b1, 1'b1, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL wd_drop: gnt=%b%b ce_b=%b rnw=%b rv1=%b rdata=%h want 00 1 1 1 5a",
               gnt0, gnt1, mem_ce_b, mem_rnw, rvalid1, rdata);
    end
    next_cyc(); #2;
    checks++;
    if ({gnt0, gnt1, mem_addr} !== {2'b10, 10'h155}) begin
      errors++;
      $display("FAIL wd_p0: gnt=%b%b addr=%h want 10 155", gnt0, gnt1, mem_addr);
    end
    next_cyc();
    clear_inputs();
    #2;
    checks++;
    if (mem[10'h030] !== 8'h5A) begin
      errors++;
      $display("FAIL wd_nowrite: mem[030]=%h want 5a", mem[10'h030]);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    mem[10'h155] <= 8'hA5;
    mem[10'h030] <= 8'h5A;
    clear_inputs();
    reset_b = 1;
    #1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_lock_bound();
    test_reset_mid_burst();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opc2_mem_arb.md
Name: opc2_mem_arb

Overview:
- Two-port arbiter sharing the single synchronous byte memory of the OPC2 system between two requesters.
- Port 0 is the opc2cpu bus adapter; port 1 is a DMA/debug loader that fills or dumps memory.
- Round-robin fairness with a bounded lock, so either side can burst without starving the other.
- Sits between both requesters and the memory array; it owns all memory control lines.

Parameters:
- AW, 10, address width in bits.
- DW, 8, data width in bits.
- LOCK_MAX, 4, maximum consecutive granted cycles for one port while the other port is requesting (range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_b  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, one per port.
- lock0, lock1  in  1  request to keep ownership for the next access (burst).
- rnw0, rnw1  in  1  1 = read, 0 = write.
- addr0, addr1  in  AW  access address.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  access accepted in this cycle.
- rvalid0, rvalid1  out  1  rdata holds read data for that port this cycle.
- rdata  out  DW  read data, shared by both ports.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rnw  out  1  memory read/write select; 0 = write.
- mem_ce_b  out  1  memory chip enable, active low.
- mem_rdata  in  DW  memory read data, returned one clock after the address.

Behaviour:
- State register `owner`: NONE, P0, P1. Pointer register `last` records the last port served. Counter `hold_cnt` is 4 bits.
- Reset (asynchronous, any time, including mid-burst):
  - owner=NONE, last=P1 (so P0 wins the first tie), hold_cnt=0, rvalid0=rvalid1=0.
  - Outputs: gnt0=gnt1=0, mem_ce_b=1, mem_rnw=1, mem_addr=0, mem_wdata=0.
  - rdata passes mem_rdata through, so its value is undefined and meaningless while rvalid=0.
- Grant timing:
  - gnt_i = (owner==Pi) & req_i, combinational from registered owner.
  - An access happens on the rising edge that ends a cycle in which gnt_i=1.
- Memory muxing:
  - When gnt_i=1: mem_addr/mem_wdata/mem_rnw come from port i and mem_ce_b=0.
  - Otherwise: mem_ce_b=1, mem_rnw=1, mem_addr=0, mem_wdata=0.
  - A write never reaches memory unless the matching gnt is high.
- Read return: rvalid_i is registered. It is 1 for exactly the one cycle after a granted read (gnt_i & rnw_i), with rdata = mem_rdata in that cycle. Writes produce no rvalid.
- Arbitration latency: a request arriving while owner=NONE is granted in the next cycle (1-cycle latency). A requester must hold req and its access fields stable until gnt.
- Next-state rules, evaluated every edge:
  - NONE: if both req, go to the port != last. If one req, go to that port. If none, stay NONE.
  - Pi with gnt_i: set last=i.
    - Other port not requesting: stay Pi if req_i, else NONE. hold_cnt=0.
    - Other port requesting, lock_i=1 and hold_cnt+1 < LOCK_MAX: stay Pi, hold_cnt+1.
    - Otherwise: switch directly to the other port and clear hold_cnt. Switching costs no idle cycle.
  - Pi without req_i (requester withdrew): go to the other port if it is requesting, else NONE. Clear hold_cnt. last is unchanged.
- Simultaneous first requests after reset: P0 wins.
- Worst-case wait for a requesting port is LOCK_MAX+1 cycles.
- The 4-bit hold_cnt never wraps: it is cleared on every switch and bounded by LOCK_MAX-1.
- A read granted on the cycle before reset asserts produces no rvalid, because reset clears the rvalid registers.
- Illegal owner encodings recover to NONE.

Test Plan:
- Reset then idle: reset_b=0 for 3 cycles, then release with no requests -> mem_ce_b=1, mem_rnw=1, mem_addr=0, gnt0=gnt1=0, rvalid=0 throughout.
- Single read, port 0: memory[0x155]=0xA5; req0=1, rnw0=1, addr0=0x155 -> gnt0 asserted in cycle 2 with mem_addr=0x155, mem_ce_b=0; rvalid0=1 with rdata=0xA5 in cycle 3.
- Simultaneous requests after reset: port 0 writes 0x11 to 0x010 while port 1 writes 0x22 to 0x020 -> P0 granted first, P1 on the next cycle; both locations hold the written bytes; no idle cycle between grants.
- Lock bound, LOCK_MAX=4: port 0 holds req0=lock0=1 while req1=1 -> gnt0 for exactly 4 consecutive cycles, then gnt1 for 1 cycle, then back to P0.
- Reset mid-burst: assert reset_b=0 one cycle after a port 1 read grant -> gnt1, rvalid1 and mem_ce_b go inactive immediately (asynchronously); after release, a tie is granted to P0.
- Withdrawn request: grant P1, then drop req1 while req0=1 -> owner moves to P0 the next cycle; no memory write occurs while gnt1=0, even with rnw1=0.
